// File: rtl/drr_packet_scheduler.sv
// Deficit-round-robin packet scheduler.
// Walks the per-destination FIFOs in round-robin order and credits each
// newly visited queue with its byte quantum. It grants one head packet at a
// time toward the egress multiplexer, then holds until that packet's last
// beat has been accepted.
module drr_packet_scheduler #(
    parameter int AXIS_FIFO_SELECT_WIDTH = 2,
    parameter int NUM_QUEUES             = 2**AXIS_FIFO_SELECT_WIDTH,
    parameter int AXIS_PKT_LEN_WIDTH     = 16,
    parameter int QUANTUM_WIDTH          = 16,
    parameter int DEFICIT_WIDTH          = AXIS_PKT_LEN_WIDTH + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_QUEUES-1:0]                    s_queue_valid,
    input  logic [NUM_QUEUES*AXIS_PKT_LEN_WIDTH-1:0] s_queue_pkt_len,
    input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0]      cfg_quantum,
    input  logic                                     cfg_enable,
    output logic                                     m_grant_valid,
    output logic [AXIS_FIFO_SELECT_WIDTH-1:0]        m_grant_queue,
    output logic [AXIS_PKT_LEN_WIDTH-1:0]            m_grant_len,
    input  logic                                     m_grant_ready,
    input  logic                                     s_pkt_done,
    output logic                                     busy
);

    localparam int SEL_W = AXIS_FIFO_SELECT_WIDTH;
    localparam int LEN_W = AXIS_PKT_LEN_WIDTH;
    localparam int CMP_W = (DEFICIT_WIDTH > LEN_W) ? DEFICIT_WIDTH : LEN_W;
    localparam int SUM_W = ((DEFICIT_WIDTH > QUANTUM_WIDTH) ? DEFICIT_WIDTH : QUANTUM_WIDTH) + 1;
    localparam logic [DEFICIT_WIDTH-1:0] DEF_MAX = '1;

    typedef enum logic [1:0] {IDLE, EVAL, GRANT, WAIT_DONE} state_t;

    state_t state, state_nxt;

    logic [SEL_W-1:0]                              ptr;
    logic                                          fresh;
    logic [NUM_QUEUES-1:0][DEFICIT_WIDTH-1:0]      deficit;

    // Packed per-queue views of the flat metadata buses
    logic [NUM_QUEUES-1:0][LEN_W-1:0]              head_len;
    logic [NUM_QUEUES-1:0][QUANTUM_WIDTH-1:0]      quantum;

    logic [LEN_W-1:0]          cur_len;
    logic [DEFICIT_WIDTH-1:0]  cur_def;
    logic [QUANTUM_WIDTH-1:0]  cur_quantum;
    logic [SEL_W-1:0]          ptr_inc;
    logic                      def_covers_len;

    // One-hot EVAL actions chosen by the next-state logic
    logic act_clear, act_add, act_grant, act_skip;

    // Deficit credit, clamped at the counter ceiling rather than wrapping
    function automatic logic [DEFICIT_WIDTH-1:0] sat_add(
        input logic [DEFICIT_WIDTH-1:0] d,
        input logic [QUANTUM_WIDTH-1:0] q
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(d) + SUM_W'(q);
        if (s > SUM_W'(DEF_MAX))
            return DEF_MAX;
        return DEFICIT_WIDTH'(s);
    endfunction

    // Debit; only called when the deficit covers the length, so no underflow
    function automatic logic [DEFICIT_WIDTH-1:0] sub_len(
        input logic [DEFICIT_WIDTH-1:0] d,
        input logic [LEN_W-1:0]         l
    );
        return DEFICIT_WIDTH'(CMP_W'(d) - CMP_W'(l));
    endfunction

    assign head_len       = s_queue_pkt_len;
    assign quantum        = cfg_quantum;
    assign cur_len        = head_len[ptr];
    assign cur_def        = deficit[ptr];
    assign cur_quantum    = quantum[ptr];
    assign def_covers_len = (CMP_W'(cur_def) >= CMP_W'(cur_len));
    assign ptr_inc        = (ptr == SEL_W'(NUM_QUEUES - 1)) ? '0 : ptr + 1'b1;

    // Next-state and EVAL action selection (one action per EVAL cycle)
    always_comb begin
        state_nxt = state;
        act_clear = 1'b0;
        act_add   = 1'b0;
        act_grant = 1'b0;
        act_skip  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable && (s_queue_valid != '0))
                    state_nxt = EVAL;
            end
            EVAL: begin
                if (!cfg_enable) begin
                    state_nxt = IDLE;
                end else if (!s_queue_valid[ptr]) begin
                    act_clear = 1'b1;
                    if (s_queue_valid == '0)
                        state_nxt = IDLE;
                end else if (fresh) begin
                    act_add = 1'b1;
                end else if (def_covers_len) begin
                    act_grant = 1'b1;
                    state_nxt = GRANT;
                end else begin
                    act_skip = 1'b1;
                end
            end
            GRANT: begin
                if (m_grant_ready)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (s_pkt_done)
                    state_nxt = EVAL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with a registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Round-robin pointer and newly-visited flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            fresh <= 1'b1;
        end else if (act_clear || act_skip) begin
            ptr   <= ptr_inc;
            fresh <= 1'b1;
        end else if (act_add) begin
            fresh <= 1'b0;
        end
    end

    // Per-queue deficit counters: cleared when empty, credited on visit, debited on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deficit <= '0;
        end else if (act_clear) begin
            deficit[ptr] <= '0;
        end else if (act_add) begin
            deficit[ptr] <= sat_add(cur_def, cur_quantum);
        end else if (act_grant) begin
            deficit[ptr] <= sub_len(cur_def, cur_len);
        end
    end

    // Grant offer, held stable until the multiplexer accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grant_valid <= 1'b0;
            m_grant_queue <= '0;
            m_grant_len   <= '0;
        end else if (act_grant) begin
            m_grant_valid <= 1'b1;
            m_grant_queue <= ptr;
            m_grant_len   <= cur_len;
        end else if ((state == GRANT) && m_grant_ready) begin
            m_grant_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_drr_packet_scheduler.sv
// Testbench for drr_packet_scheduler: directed scenarios plus randomized
// traffic, compared grant by grant against a transaction-level DRR model.
module tb_drr_packet_scheduler;

    localparam int NQ   = 4;
    localparam int LW   = 16;
    localparam int QW   = 16;
    localparam int DMAX = 131071;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NQ-1:0]     s_queue_valid = '0;
    logic [NQ*LW-1:0]  s_queue_pkt_len = '0;
    logic [NQ*QW-1:0]  cfg_quantum = '0;
    logic              cfg_enable = 1'b0;
    logic              m_grant_valid;
    logic [1:0]        m_grant_queue;
    logic [LW-1:0]     m_grant_len;
    logic              m_grant_ready = 1'b0;
    logic              s_pkt_done = 1'b0;
    logic              busy;

    // Narrow-deficit instance: lets the counter reach its ceiling with legal lengths
    logic [NQ-1:0]     sat_valid = '0;
    logic [NQ*LW-1:0]  sat_len = '0;
    logic [NQ*QW-1:0]  sat_quantum = '0;
    logic              sat_enable = 1'b0;
    logic              sat_gvalid;
    logic [1:0]        sat_gqueue;
    logic [LW-1:0]     sat_glen;
    logic              sat_busy;

    int n_chk = 0;
    int n_err = 0;

    int quanta[NQ];
    int pq[NQ][$];
    int m_ptr;
    int m_fresh;
    int m_def[NQ];
    int got_q[$];

    drr_packet_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .s_queue_valid(s_queue_valid), .s_queue_pkt_len(s_queue_pkt_len),
        .cfg_quantum(cfg_quantum), .cfg_enable(cfg_enable),
        .m_grant_valid(m_grant_valid), .m_grant_queue(m_grant_queue),
        .m_grant_len(m_grant_len), .m_grant_ready(m_grant_ready),
        .s_pkt_done(s_pkt_done), .busy(busy)
    );

    drr_packet_scheduler #(.DEFICIT_WIDTH(12)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .s_queue_valid(sat_valid), .s_queue_pkt_len(sat_len),
        .cfg_quantum(sat_quantum), .cfg_enable(sat_enable),
        .m_grant_valid(sat_gvalid), .m_grant_queue(sat_gqueue),
        .m_grant_len(sat_glen), .m_grant_ready(1'b0),
        .s_pkt_done(1'b0), .busy(sat_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic update_heads();
        for (int i = 0; i < NQ; i++) begin
            s_queue_valid[i]         = (pq[i].size() != 0);
            s_queue_pkt_len[i*LW+:LW] = (pq[i].size() != 0) ? LW'(pq[i][0]) : '0;
            cfg_quantum[i*QW+:QW]     = QW'(quanta[i]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        m_grant_ready = 1'b0;
        s_pkt_done = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            pq[i].delete();
            quanta[i] = 0;
            m_def[i] = 0;
        end
        update_heads();
        m_ptr = 0;
        m_fresh = 1;
        got_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Transaction-level DRR: walk queues until one head packet fits its deficit
    task automatic model_next(output bit found, output int q, output int len);
        bit any;
        found = 1'b0;
        q = 0;
        len = 0;
        any = 1'b0;
        for (int i = 0; i < NQ; i++) if (pq[i].size() != 0) any = 1'b1;
        if (!any) return;
        for (int step = 0; step < 100000; step++) begin
            if (pq[m_ptr].size() == 0) begin
                m_def[m_ptr] = 0;
                m_ptr = (m_ptr + 1) % NQ;
                m_fresh = 1;
                any = 1'b0;
                for (int i = 0; i < NQ; i++) if (pq[i].size() != 0) any = 1'b1;
                if (!any) return;
            end else if (m_fresh != 0) begin
                m_def[m_ptr] = (m_def[m_ptr] + quanta[m_ptr] > DMAX) ? DMAX : m_def[m_ptr] + quanta[m_ptr];
                m_fresh = 0;
            end else if (m_def[m_ptr] >= pq[m_ptr][0]) begin
                m_def[m_ptr] -= pq[m_ptr][0];
                found = 1'b1;
                q = m_ptr;
                len = pq[m_ptr][0];
                return;
            end else begin
                m_ptr = (m_ptr + 1) % NQ;
                m_fresh = 1;
            end
        end
    endtask

    task automatic wait_grant(output bit ok);
        int cnt;
        cnt = 0;
        while (!m_grant_valid && cnt < 400) begin
            tick();
            cnt++;
        end
        ok = m_grant_valid;
        if (!ok) chk("grant_timeout", 32'(m_grant_valid), 32'd1);
    endtask

    task automatic accept_grant(input int delay);
        for (int k = 0; k < delay; k++) tick();
        m_grant_ready = 1'b1;
        tick();
        m_grant_ready = 1'b0;
        chk("valid_drop_after_ready", 32'(m_grant_valid), 32'd0);
    endtask

    task automatic finish_pkt(input int q, input int delay);
        for (int k = 0; k < delay; k++) tick();
        void'(pq[q].pop_front());
        update_heads();
        s_pkt_done = 1'b1;
        tick();
        s_pkt_done = 1'b0;
    endtask

    // Drain all loaded queues, checking every grant against the model
    task automatic run_traffic(input bit rand_delays);
        bit found, ok;
        int eq, el;
        update_heads();
        cfg_enable = 1'b1;
        forever begin
            model_next(found, eq, el);
            if (!found) break;
            wait_grant(ok);
            if (!ok) return;
            chk("grant_queue", 32'(m_grant_queue), 32'(eq));
            chk("grant_len", 32'(m_grant_len), 32'(el));
            chk("grant_deficit", 32'(dut.deficit[eq]), 32'(m_def[eq]));
            got_q.push_back(int'(m_grant_queue));
            accept_grant(rand_delays ? $urandom_range(3, 0) : 0);
            finish_pkt(eq, rand_delays ? $urandom_range(3, 0) : 0);
        end
        for (int k = 0; k < 6; k++) tick();
        chk("drained_busy", 32'(busy), 32'd0);
        chk("drained_valid", 32'(m_grant_valid), 32'd0);
    endtask

    initial begin
        bit ok;
        bit seen;
        int exp_w[12];
        int exp_e[5];

        // Reset state
        do_reset();
        chk("rst_valid", 32'(m_grant_valid), 32'd0);
        chk("rst_queue", 32'(m_grant_queue), 32'd0);
        chk("rst_len", 32'(m_grant_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ptr", 32'(dut.ptr), 32'd0);
        chk("rst_fresh", 32'(dut.fresh), 32'd1);
        chk("rst_deficit", 32'(dut.deficit), 32'd0);

        // Best-case latency: single queue, 64-byte packet, quantum 1500
        quanta[0] = 1500;
        pq[0].push_back(64);
        update_heads();
        cfg_enable = 1'b1;
        tick();
        chk("lat_c1", 32'(m_grant_valid), 32'd0);
        tick();
        chk("lat_c2", 32'(m_grant_valid), 32'd0);
        tick();
        chk("lat_c3", 32'(m_grant_valid), 32'd1);
        chk("lat_queue", 32'(m_grant_queue), 32'd0);
        chk("lat_len", 32'(m_grant_len), 32'd64);
        chk("lat_deficit", 32'(dut.deficit[0]), 32'd1436);

        // Equal quanta, 1500-byte packets everywhere
        do_reset();
        for (int i = 0; i < NQ; i++) begin
            quanta[i] = 1500;
            pq[i].push_back(1500);
        end
        pq[0].push_back(1500);
        run_traffic(1'b0);
        exp_e = '{0, 1, 2, 3, 0};
        chk("equal_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) chk("equal_order", 32'(got_q[i]), 32'(exp_e[i]));

        // Weighted 2:1 sharing
        do_reset();
        quanta[0] = 3000;
        quanta[1] = 1500;
        for (int i = 0; i < 8; i++) pq[0].push_back(1500);
        for (int i = 0; i < 4; i++) pq[1].push_back(1500);
        run_traffic(1'b0);
        exp_w = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        chk("weighted_count", 32'(got_q.size()), 32'd12);
        for (int i = 0; i < 12 && i < got_q.size(); i++) chk("weighted_order", 32'(got_q[i]), 32'(exp_w[i]));

        // Empty queue loses its leftover deficit
        do_reset();
        quanta[2] = 2000;
        quanta[3] = 200;
        pq[2].push_back(1500);
        pq[3].push_back(100);
        update_heads();
        cfg_enable = 1'b1;
        wait_grant(ok);
        chk("empty_grant_q", 32'(m_grant_queue), 32'd2);
        chk("empty_def_before", 32'(dut.deficit[2]), 32'd500);
        accept_grant(0);
        finish_pkt(2, 1);
        chk("empty_ptr_hold", 32'(dut.ptr), 32'd2);
        tick();
        chk("empty_def_cleared", 32'(dut.deficit[2]), 32'd0);
        chk("empty_ptr_adv", 32'(dut.ptr), 32'd3);

        // Enable dropped while waiting for the packet to finish
        do_reset();
        quanta[0] = 1500;
        pq[0].push_back(64);
        pq[0].push_back(64);
        update_heads();
        cfg_enable = 1'b1;
        wait_grant(ok);
        accept_grant(0);
        cfg_enable = 1'b0;
        finish_pkt(0, 1);
        chk("dis_busy_eval", 32'(busy), 32'd1);
        tick();
        chk("dis_busy_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_grant_valid) seen = 1'b1;
        end
        chk("dis_no_grant", 32'(seen), 32'd0);

        // Asynchronous reset while a grant is pending
        do_reset();
        quanta[1] = 1500;
        pq[1].push_back(200);
        update_heads();
        cfg_enable = 1'b1;
        wait_grant(ok);
        chk("arst_pre_valid", 32'(m_grant_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(m_grant_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_deficit", 32'(dut.deficit), 32'd0);
        chk("arst_ptr", 32'(dut.ptr), 32'd0);

        // Saturation on the 12-bit-deficit instance: length 5000 is never served
        do_reset();
        sat_quantum[QW-1:0] = 16'd3000;
        sat_len[LW-1:0] = 16'd5000;
        sat_valid = 4'b0001;
        sat_enable = 1'b1;
        tick();
        tick();
        chk("sat_first_add", 32'(dut_sat.deficit[0]), 32'd3000);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (sat_gvalid) seen = 1'b1;
        end
        chk("sat_ceiling", 32'(dut_sat.deficit[0]), 32'd4095);
        chk("sat_no_grant", 32'(seen), 32'd0);
        sat_enable = 1'b0;
        sat_valid = '0;

        // Randomized traffic against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < NQ; i++) begin
                quanta[i] = $urandom_range(2000, 200);
                for (int p = 0; p < int'($urandom_range(5, 0)); p++)
                    pq[i].push_back(($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(1600, 1)));
            end
            run_traffic(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
